fht_stage_sequencer: RTL and testbench
======================================

Name: fht_stage_sequencer

Overview:
- Sequences one N-point in-place radix-2 FHT pass set: walks every stage and butterfly, and generates the twiddle ROM address, stage-zero flag and data-RAM read address pair per butterfly.
- Sits between the top-level FHT control and the twiddle ROM block plus butterfly datapath.
- Provides a valid strobe aligned to ROM output latency, stall support, and an inter-stage drain gap so stage s+1 never reads data still in flight from stage s.

Parameters:
- N_BIT, 8, log2 of transform length N (N = 2^N_BIT; stages = N_BIT).
- A_BIT, 6, twiddle ROM address width; must equal N_BIT-2 (ROM holds N/4 entries, first quadrant).
- ROM_LAT, 1, twiddle ROM read latency in cycles.
- BF_LAT, 4, butterfly datapath plus write-back latency; sets the inter-stage gap.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous active-high reset.
- iSTART  in  1  one-cycle start pulse; honoured only in IDLE.
- iSTALL  in  1  datapath back-pressure; freezes issue while high.
- oROM_ADDR  out  A_BIT  twiddle ROM address (iADDR of ROM block).
- oQUAD  out  1  twiddle index MSB (second quadrant select).
- oST_ZERO  out  1  high while issuing stage 0 (iST_ZERO of ROM block).
- oRD_ADDR_A  out  N_BIT  butterfly upper operand address.
- oRD_ADDR_B  out  N_BIT  butterfly lower operand address.
- oSTAGE  out  clog2(N_BIT)  current stage index.
- oBF_VALID  out  1  butterfly operands/twiddle valid at datapath (issue delayed ROM_LAT).
- oBUSY  out  1  high from accepted start until oDONE.
- oDONE  out  1  one-cycle pulse when the final write-back window has elapsed.

Behaviour:
- Reset: all outputs 0. FSM=IDLE; stage and butterfly counters 0; valid pipeline cleared. Reset mid-run aborts immediately; no oDONE is issued.
- States:
  - IDLE: iSTART -> RUN; oBUSY rises next cycle.
  - RUN: issues one butterfly per cycle when iSTALL=0. When b reaches N/2-1 and is issued -> GAP.
  - GAP: counts ROM_LAT+BF_LAT cycles. If s<N_BIT-1: s++, b=0 -> RUN. Else -> DONE.
  - DONE: oDONE=1 for one cycle, oBUSY=0 -> IDLE.
- Per issue in stage s, butterfly b:
  - k = b mod 2^s; g = b >> s.
  - A = g*2^(s+1) + k; B = A + 2^s.
  - t = k << (N_BIT-1-s), width N_BIT-1.
  - oROM_ADDR = t[A_BIT-1:0]; oQUAD = t[N_BIT-2].
- Address outputs and oST_ZERO are registered and change on the issue cycle. oRD_ADDR_A/B, oQUAD and oSTAGE are also delayed through a ROM_LAT shift so they align with oBF_VALID. oROM_ADDR is not delayed.
- Stall: iSTALL=1 in RUN holds counters and ROM address, and inserts a bubble (0) into the valid pipeline. Already-issued entries keep flowing. iSTALL is ignored in GAP, DONE and IDLE.
- iSTART while oBUSY=1: ignored. iSTART in the same cycle as DONE: ignored (the block is not yet in IDLE).
- Total cycles with no stalls, start to oDONE: N_BIT*(N/2 + ROM_LAT + BF_LAT) + 1.
- oST_ZERO is 1 only for stage-0 issues.

Decomposition:
- Shared package fht_pkg holds:
  - FSM state enum (IDLE, RUN, GAP, DONE).
  - clog2 function.
  - default N_BIT/A_BIT constants, shared with the ROM block and datapath.
- One sub-module, fht_addr_gen: combinational mapping of (s, b) to (A, B, t). Instantiated once and unit-testable on its own.

Test Plan:
- Reset mid-run (assert iRESET at stage 2) -> all outputs 0 next edge, FSM IDLE, no oDONE; fresh iSTART restarts from stage 0.
- N_BIT=4, ROM_LAT=1, BF_LAT=4, start, no stall:
  - stage 0 issues A/B = (0,1),(2,3)..(14,15), t=0, oST_ZERO=1.
  - stage 1 issues (0,2),(1,3),(4,6)..; t alternates 0,4 -> oROM_ADDR=0, oQUAD 0 then 1.
  - oDONE at cycle 4*(8+5)+1 = 53.
- Stage 3 (N_BIT=4): b=5 -> A=5, B=13, t=5 -> oROM_ADDR=1, oQUAD=1, oST_ZERO=0.
- iSTALL high 3 cycles mid stage 1:
  - oBF_VALID gap of 3 with counters frozen.
  - issue sequence identical to the no-stall run.
  - oDONE delayed by exactly 3.
- iSTART pulses during RUN, during GAP, and in the same cycle as DONE -> all ignored; a single oDONE is produced.
- Check oBF_VALID count = N_BIT*N/2 (32 for N_BIT=4) and that every (A,B) pair per stage covers 0..N-1 exactly once.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared FHT definitions: sequencer state encoding, default transform sizing
// and a constant-foldable clog2 used to size ports and counters.
package fht_pkg;

    localparam int FHT_N_BIT = 8;
    localparam int FHT_A_BIT = FHT_N_BIT - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } fht_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fht_addr_gen.sv
// Maps (stage, butterfly) to the in-place operand address pair and the
// twiddle index for a radix-2 FHT pass.
module fht_addr_gen
    import fht_pkg::*;
#(
    parameter int N_BIT = FHT_N_BIT,
    localparam int S_W  = clog2(N_BIT)
) (
    input  logic [S_W-1:0]   i_stage,
    input  logic [N_BIT-2:0] i_bf,
    output logic [N_BIT-1:0] o_addr_a,
    output logic [N_BIT-1:0] o_addr_b,
    output logic [N_BIT-2:0] o_tw
);

    logic [N_BIT-1:0] w_b_ext;
    logic [N_BIT-1:0] w_one;
    logic [N_BIT-1:0] w_mask;
    logic [N_BIT-1:0] w_k;
    logic [N_BIT-1:0] w_g;
    logic [N_BIT-1:0] w_a;
    logic [N_BIT-1:0] w_t_full;
    logic [S_W-1:0]   w_tw_shift;

    assign w_b_ext    = {1'b0, i_bf};
    assign w_one      = {{(N_BIT-1){1'b0}}, 1'b1} << i_stage;
    assign w_mask     = w_one - {{(N_BIT-1){1'b0}}, 1'b1};
    assign w_k        = w_b_ext & w_mask;
    assign w_g        = w_b_ext >> i_stage;
    // Shift by s then by one: s+1 would overflow the stage width on the last stage.
    assign w_a        = ((w_g << i_stage) << 1) | w_k;
    assign w_tw_shift = S_W'(N_BIT - 1) - i_stage;
    assign w_t_full   = w_k << w_tw_shift;

    assign o_addr_a = w_a;
    assign o_addr_b = w_a | w_one;
    assign o_tw     = w_t_full[N_BIT-2:0];

endmodule

// File: rtl/fht_stage_sequencer.sv
// Walks every stage and butterfly of an in-place radix-2 FHT, issuing twiddle
// ROM addresses and operand address pairs aligned to the ROM read latency.
module fht_stage_sequencer
    import fht_pkg::*;
#(
    parameter int N_BIT   = FHT_N_BIT,
    parameter int A_BIT   = FHT_A_BIT,
    parameter int ROM_LAT = 1,
    parameter int BF_LAT  = 4,
    localparam int S_W    = clog2(N_BIT)
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iSTALL,
    output logic [A_BIT-1:0] oROM_ADDR,
    output logic             oQUAD,
    output logic             oST_ZERO,
    output logic [N_BIT-1:0] oRD_ADDR_A,
    output logic [N_BIT-1:0] oRD_ADDR_B,
    output logic [S_W-1:0]   oSTAGE,
    output logic             oBF_VALID,
    output logic             oBUSY,
    output logic             oDONE
);

    localparam int GAP_LEN = ROM_LAT + BF_LAT;
    localparam int GAP_W   = clog2(GAP_LEN);
    localparam logic [N_BIT-2:0] BF_LAST  = (N_BIT-1)'((1 << (N_BIT - 1)) - 1);
    localparam logic [S_W-1:0]   ST_LAST  = S_W'(N_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

    fht_state_e       r_state;
    logic [S_W-1:0]   r_stage;
    logic [N_BIT-2:0] r_bf;
    logic [GAP_W-1:0] r_gap;
    logic             r_busy;
    logic             r_done;
    logic             r_st_zero;
    logic [A_BIT-1:0] r_rom_addr;
    logic             r_vld  [0:ROM_LAT];
    logic             r_quad [0:ROM_LAT];
    logic [N_BIT-1:0] r_a    [0:ROM_LAT];
    logic [N_BIT-1:0] r_b    [0:ROM_LAT];
    logic [S_W-1:0]   r_stg  [0:ROM_LAT];

    logic [N_BIT-1:0] w_addr_a;
    logic [N_BIT-1:0] w_addr_b;
    logic [N_BIT-2:0] w_tw;
    logic             w_issue;

    assign w_issue = (r_state == ST_RUN) && !iSTALL;

    fht_addr_gen #(
        .N_BIT (N_BIT)
    ) u_addr_gen (
        .i_stage  (r_stage),
        .i_bf     (r_bf),
        .o_addr_a (w_addr_a),
        .o_addr_b (w_addr_b),
        .o_tw     (w_tw)
    );

    // Sequencer FSM, issue registers and the ROM-latency alignment shift.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_state    <= ST_IDLE;
            r_stage    <= '0;
            r_bf       <= '0;
            r_gap      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_st_zero  <= 1'b0;
            r_rom_addr <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_vld[i]  <= 1'b0;
                r_quad[i] <= 1'b0;
                r_a[i]    <= '0;
                r_b[i]    <= '0;
                r_stg[i]  <= '0;
            end
        end else begin
            r_vld[0] <= w_issue;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_quad[i] <= r_quad[i-1];
                r_a[i]    <= r_a[i-1];
                r_b[i]    <= r_b[i-1];
                r_stg[i]  <= r_stg[i-1];
            end
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_st_zero <= 1'b0;
                    if (iSTART) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_stage <= '0;
                        r_bf    <= '0;
                    end
                end
                ST_RUN: begin
                    r_st_zero <= (r_stage == '0);
                    if (!iSTALL) begin
                        r_rom_addr <= w_tw[A_BIT-1:0];
                        r_quad[0]  <= w_tw[N_BIT-2];
                        r_a[0]     <= w_addr_a;
                        r_b[0]     <= w_addr_b;
                        r_stg[0]   <= r_stage;
                        if (r_bf == BF_LAST) begin
                            r_state <= ST_GAP;
                            r_gap   <= '0;
                        end else begin
                            r_bf <= r_bf + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // Drain window: the next stage must not read results still in flight.
                    r_st_zero <= 1'b0;
                    if (r_gap == GAP_LAST) begin
                        if (r_stage == ST_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                            r_bf    <= '0;
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_st_zero <= 1'b0;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign oROM_ADDR  = r_rom_addr;
    assign oQUAD      = r_quad[ROM_LAT];
    assign oST_ZERO   = r_st_zero;
    assign oRD_ADDR_A = r_a[ROM_LAT];
    assign oRD_ADDR_B = r_b[ROM_LAT];
    assign oSTAGE     = r_stg[ROM_LAT];
    assign oBF_VALID  = r_vld[ROM_LAT];
    assign oBUSY      = r_busy;
    assign oDONE      = r_done;

endmodule

// File: tb/tb_fht_stage_sequencer.sv
// Scoreboard bench for a 16-point sequencer: expected issues are queued at
// start and matched against every oBF_VALID beat.
module tb_fht_stage_sequencer;

    localparam int NB   = 4;
    localparam int AB   = 2;
    localparam int N    = 1 << NB;
    localparam int HALF = N / 2;
    localparam int QTR  = N / 4;

    logic          iCLK;
    logic          iRESET;
    logic          iSTART;
    logic          iSTALL;
    logic [AB-1:0] oROM_ADDR;
    logic          oQUAD;
    logic          oST_ZERO;
    logic [NB-1:0] oRD_ADDR_A;
    logic [NB-1:0] oRD_ADDR_B;
    logic [1:0]    oSTAGE;
    logic          oBF_VALID;
    logic          oBUSY;
    logic          oDONE;

    typedef struct {
        int stage;
        int a;
        int b;
        int rom;
        int quad;
        int stz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc;
    int   done_cyc;
    int   done_cnt;
    int   n_valid;
    int   cov[0:NB-1][0:N-1];
    int   st_first[0:NB-1];
    int   st_last[0:NB-1];
    int   rom_hist;
    int   stz_hist;

    fht_stage_sequencer #(
        .N_BIT   (NB),
        .A_BIT   (AB),
        .ROM_LAT (1),
        .BF_LAT  (4)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iSTART     (iSTART),
        .iSTALL     (iSTALL),
        .oROM_ADDR  (oROM_ADDR),
        .oQUAD      (oQUAD),
        .oST_ZERO   (oST_ZERO),
        .oRD_ADDR_A (oRD_ADDR_A),
        .oRD_ADDR_B (oRD_ADDR_B),
        .oSTAGE     (oSTAGE),
        .oBF_VALID  (oBF_VALID),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_value(tag, int'({oROM_ADDR, oQUAD, oST_ZERO, oRD_ADDR_A, oRD_ADDR_B,
                               oSTAGE, oBF_VALID, oBUSY, oDONE}), 0);
    endtask

    // Reference schedule: groups of span 2^(s+1), k walks the first half.
    task automatic push_expected();
        exp_t e;
        int   hs;
        int   t;
        for (int s = 0; s < NB; s++) begin
            hs = 1 << s;
            for (int g = 0; g < N / (2 * hs); g++) begin
                for (int k = 0; k < hs; k++) begin
                    e.stage = s;
                    e.a     = g * 2 * hs + k;
                    e.b     = e.a + hs;
                    t       = k * (HALF / hs);
                    e.rom   = t % QTR;
                    e.quad  = t / QTR;
                    e.stz   = (s == 0) ? 1 : 0;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic do_start();
        @(negedge iCLK);
        exp_q.delete();
        done_cnt = 0;
        n_valid  = 0;
        for (int s = 0; s < NB; s++) begin
            st_first[s] = -1;
            st_last[s]  = -1;
            for (int a = 0; a < N; a++) cov[s][a] = 0;
        end
        push_expected();
        start_cyc = cyc + 1;
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int exp_lat, input int stall_stage);
        int ok;
        for (int i = 0; i < 200 && done_cnt == 0; i++) @(negedge iCLK);
        check_value({tag, "_done_seen"}, done_cnt, 1);
        check_value({tag, "_latency"}, done_cyc - start_cyc, exp_lat);
        repeat (20) @(negedge iCLK);
        check_value({tag, "_single_done"}, done_cnt, 1);
        check_value({tag, "_busy_idle"}, oBUSY, 0);
        check_value({tag, "_valid_count"}, n_valid, NB * HALF);
        check_value({tag, "_queue_empty"}, exp_q.size(), 0);
        for (int s = 0; s < NB; s++) begin
            ok = 1;
            for (int a = 0; a < N; a++) if (cov[s][a] != 1) ok = 0;
            check_value({tag, "_cover"}, ok, 1);
            check_value({tag, "_bubbles"}, st_last[s] - st_first[s] + 1 - HALF,
                        (s == stall_stage) ? 3 : 0);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        rom_hist = 0;
        stz_hist = 0;
        forever begin
            @(posedge iCLK);
            #1;
            cyc++;
            if (oBF_VALID) begin
                if (exp_q.size() == 0) begin
                    check_value("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_value("rd_addr_a", oRD_ADDR_A, e.a);
                    check_value("rd_addr_b", oRD_ADDR_B, e.b);
                    check_value("stage", oSTAGE, e.stage);
                    check_value("quad", oQUAD, e.quad);
                    check_value("rom_addr", rom_hist, e.rom);
                    check_value("st_zero", stz_hist, e.stz);
                    n_valid++;
                    cov[e.stage][oRD_ADDR_A]++;
                    cov[e.stage][oRD_ADDR_B]++;
                    if (st_first[e.stage] < 0) st_first[e.stage] = cyc;
                    st_last[e.stage] = cyc;
                end
            end
            if (oDONE) begin
                done_cnt++;
                done_cyc = cyc;
            end
            rom_hist = oROM_ADDR;
            stz_hist = oST_ZERO;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        iRESET = 1'b1;
        iSTART = 1'b0;
        iSTALL = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        check_all_zero("reset_outputs");
        @(negedge iCLK);
        iRESET = 1'b0;
        repeat (2) @(negedge iCLK);

        // Plain run.
        do_start();
        check_value("busy_after_start", oBUSY, 1);
        finish_run("plain", 53, -1);

        // Three stall cycles inside stage 1.
        do_start();
        repeat (15) @(negedge iCLK);
        iSTALL = 1'b1;
        repeat (3) @(negedge iCLK);
        iSTALL = 1'b0;
        finish_run("stall", 56, 1);

        // Start pulses in RUN, GAP and the DONE cycle must all be ignored.
        do_start();
        repeat (4) @(negedge iCLK);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        repeat (4) @(negedge iCLK);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        repeat (42) @(negedge iCLK);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        finish_run("start_ignored", 53, -1);

        // Reset during stage 2 aborts without oDONE.
        do_start();
        repeat (27) @(negedge iCLK);
        check_value("midrun_stage2_busy", oBUSY, 1);
        iRESET = 1'b1;
        #1;
        check_all_zero("midrun_reset_async");
        @(posedge iCLK);
        #2;
        check_all_zero("midrun_reset_edge");
        exp_q.delete();
        @(negedge iCLK);
        iRESET = 1'b0;
        repeat (70) @(negedge iCLK);
        check_value("midrun_no_done", done_cnt, 0);
        check_value("midrun_idle", oBUSY, 0);

        // Fresh start after abort runs the full schedule from stage 0.
        do_start();
        finish_run("restart", 53, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
